// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: per-neuron spike counting over a window of timesteps,
// double-buffered into a shadow copy that streams out as gain-scaled 16-bit rates.
module spike_rate_decoder #(
  parameter int NUM_NEURONS = 1024,
  parameter int COUNT_WIDTH = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_NEURONS-1:0]    spikes_in,
  input  logic                      spikes_valid,
  input  logic [15:0]               cfg_window,
  input  logic [15:0]               cfg_gain,
  output logic [32*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      window_done,
  output logic                      busy,
  output logic                      overrun,
  output logic [15:0]               dropped_windows
);

  localparam int LANES     = 32;
  localparam int NUM_BEATS = NUM_NEURONS / LANES;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int PW        = COUNT_WIDTH + 16;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [BW-1:0]          LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [PW-1:0]          LANE_MAX  = PW'((1 << (DATA_WIDTH - 1)) - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_e;

  state_e                                  state_q, state_d;
  logic [NUM_NEURONS-1:0][COUNT_WIDTH-1:0] live_cnt_q, live_cnt_d;
  logic [NUM_NEURONS-1:0][COUNT_WIDTH-1:0] shadow_cnt_q, shadow_cnt_d;
  logic [NUM_NEURONS-1:0][COUNT_WIDTH-1:0] cnt_next;
  logic [15:0]                             step_cnt_q, step_cnt_d;
  logic [15:0]                             win_len_q, win_len_d;
  logic [15:0]                             win_len_eff;
  logic                                    win_close;
  logic [BW-1:0]                           beat_idx_q, beat_idx_d;
  logic [BW-1:0]                           beat_sel;
  logic [BW+4:0]                           lane_idx;
  logic [COUNT_WIDTH-1:0]                  lane_cnt;
  logic [PW-1:0]                           lane_prod;
  logic [PW-1:0]                           lane_scaled;
  logic [32*DATA_WIDTH-1:0]                beat_data;
  logic [32*DATA_WIDTH-1:0]                tdata_q, tdata_d;
  logic                                    tvalid_q, tvalid_d;
  logic                                    tlast_q, tlast_d;
  logic                                    window_done_q, window_done_d;
  logic                                    overrun_q, overrun_d;
  logic [15:0]                             dropped_q, dropped_d;

  // Accumulate this timestep's spikes and detect the window-closing step
  always_comb begin
    win_len_eff = (step_cnt_q == '0) ? ((cfg_window == '0) ? 16'd1 : cfg_window) : win_len_q;
    win_close   = spikes_valid && (step_cnt_q == win_len_eff - 16'd1);
    cnt_next    = live_cnt_q;
    for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
      if (spikes_valid && spikes_in[n] && (live_cnt_q[n] != CNT_MAX))
        cnt_next[n] = live_cnt_q[n] + 1'b1;
    end
    live_cnt_d = win_close ? '0 : cnt_next;
    step_cnt_d = step_cnt_q;
    win_len_d  = win_len_q;
    if (spikes_valid) begin
      if (step_cnt_q == '0) win_len_d = win_len_eff;
      step_cnt_d = win_close ? '0 : step_cnt_q + 16'd1;
    end
  end

  // Next beat's lanes; beat 0 comes straight from the closing counts so it can be
  // registered in the close cycle, before the shadow copy itself is written
  always_comb begin
    beat_sel  = (state_q == ST_IDLE) ? '0 : beat_idx_q + 1'b1;
    beat_data = '0;
    lane_idx  = '0;
    lane_cnt  = '0;
    lane_prod = '0;
    lane_scaled = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_idx    = {beat_sel, 5'(i)};
      lane_cnt    = (state_q == ST_IDLE) ? cnt_next[lane_idx] : shadow_cnt_q[lane_idx];
      lane_prod   = PW'(lane_cnt) * PW'(cfg_gain);
      lane_scaled = lane_prod >> 8;
      beat_data[i*DATA_WIDTH +: DATA_WIDTH] =
        (lane_scaled > LANE_MAX) ? DATA_WIDTH'(LANE_MAX) : DATA_WIDTH'(lane_scaled);
    end
  end

  // Stream FSM: accept or drop closed windows, advance beats on handshake
  always_comb begin
    state_d       = state_q;
    shadow_cnt_d  = shadow_cnt_q;
    beat_idx_d    = beat_idx_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    window_done_d = 1'b0;
    overrun_d     = overrun_q;
    dropped_d     = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (win_close) begin
          shadow_cnt_d  = cnt_next;
          window_done_d = 1'b1;
          beat_idx_d    = '0;
          tdata_d       = beat_data;
          tvalid_d      = 1'b1;
          tlast_d       = (LAST_BEAT == '0);
          state_d       = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (win_close) begin
          overrun_d = 1'b1;
          if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
        end
        if (tvalid_q && m_axis_tready) begin
          if (beat_idx_q == LAST_BEAT) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = ST_IDLE;
          end else begin
            beat_idx_d = beat_sel;
            tdata_d    = beat_data;
            tlast_d    = (beat_sel == LAST_BEAT);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      live_cnt_q    <= '0;
      shadow_cnt_q  <= '0;
      step_cnt_q    <= '0;
      win_len_q     <= '0;
      beat_idx_q    <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      window_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q       <= state_d;
      live_cnt_q    <= live_cnt_d;
      shadow_cnt_q  <= shadow_cnt_d;
      step_cnt_q    <= step_cnt_d;
      win_len_q     <= win_len_d;
      beat_idx_q    <= beat_idx_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
      window_done_q <= window_done_d;
      overrun_q     <= overrun_d;
      dropped_q     <= dropped_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign window_done     = window_done_q;
  assign busy            = (state_q == ST_STREAM);
  assign overrun         = overrun_q;
  assign dropped_windows = dropped_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed testbench for spike_rate_decoder with hand-computed expectations.
module tb_spike_rate_decoder;

  localparam int NN = 1024;

  logic            clk = 1'b0;
  logic            rst;
  logic [NN-1:0]   spikes_in;
  logic            spikes_valid;
  logic [15:0]     cfg_window;
  logic [15:0]     cfg_gain;
  logic [511:0]    m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic            window_done;
  logic            busy;
  logic            overrun;
  logic [15:0]     dropped_windows;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  int wd_count = 0;

  logic [511:0] cap_data [64];
  logic         cap_last [64];

  spike_rate_decoder #(.NUM_NEURONS(NN), .COUNT_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .spikes_in(spikes_in), .spikes_valid(spikes_valid),
    .cfg_window(cfg_window), .cfg_gain(cfg_gain),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .window_done(window_done), .busy(busy), .overrun(overrun),
    .dropped_windows(dropped_windows)
  );

  always #5 clk = ~clk;

  // Count window_done pulses away from the clock edge
  always @(negedge clk) if (window_done === 1'b1) wd_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; spikes_valid = 1'b0; spikes_in = '0; m_axis_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic step(input logic [NN-1:0] sp);
    spikes_in = sp; spikes_valid = 1'b1;
    tick();
    spikes_valid = 1'b0; spikes_in = '0;
  endtask

  // Gather one streamed vector; mode 1 stalls beat 7 for 10 cycles then randomises tready
  task automatic collect(input int mode, output int nbeats, output int nlast,
                         output int unstable, output bit timeout);
    logic         stalled, rdy, done;
    logic [511:0] hold_d;
    logic         hold_l;
    int           stall_left, stall_used;
    nbeats = 0; nlast = 0; unstable = 0; timeout = 1'b1;
    stalled = 1'b0; done = 1'b0; stall_left = 0; stall_used = 0;
    hold_d = '0; hold_l = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (stalled && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l))
        unstable++;
      if (mode == 0) rdy = 1'b1;
      else begin
        if (nbeats == 7 && m_axis_tvalid === 1'b1 && stall_used == 0) begin
          stall_left = 10; stall_used = 1;
        end
        if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
        else if (nbeats > 7) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
      end
      m_axis_tready = rdy;
      stalled = (m_axis_tvalid === 1'b1) && !rdy;
      hold_d = m_axis_tdata; hold_l = m_axis_tlast;
      if (m_axis_tvalid === 1'b1 && rdy) begin
        if (nbeats < 64) begin
          cap_data[nbeats] = m_axis_tdata;
          cap_last[nbeats] = m_axis_tlast;
        end
        nbeats++;
        if (m_axis_tlast === 1'b1) begin nlast++; done = 1'b1; end
        if (nbeats >= 40) done = 1'b1;
      end
      tick();
      if (done) begin timeout = 1'b0; break; end
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++; if (m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); end
    vec_cnt++; if (m_axis_tlast !== 1'b0) begin err_cnt++; $display("FAIL reset_tlast got %b exp 0", m_axis_tlast); end
    vec_cnt++; if (m_axis_tdata !== '0) begin err_cnt++; $display("FAIL reset_tdata got %h exp 0", m_axis_tdata); end
    vec_cnt++; if (window_done !== 1'b0) begin err_cnt++; $display("FAIL reset_window_done got %b exp 0", window_done); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    vec_cnt++; if (dropped_windows !== 16'd0) begin err_cnt++; $display("FAIL reset_dropped got %0d exp 0", dropped_windows); end
  endtask

  task automatic test_basic();
    logic [NN-1:0] sp0, sp1;
    logic [511:0]  exp;
    int nb, nl, us, wd0;
    bit to;
    do_reset();
    cfg_window = 16'd4; cfg_gain = 16'h0100;
    wd0 = wd_count;
    sp0 = '0; sp0[0] = 1'b1;
    sp1 = sp0; sp1[NN-1] = 1'b1;
    step(sp0); step(sp1); step(sp0);
    vec_cnt++; if (window_done !== 1'b0) begin err_cnt++; $display("FAIL basic_early_done got %b exp 0", window_done); end
    step(sp1);
    vec_cnt++; if (window_done !== 1'b1) begin err_cnt++; $display("FAIL basic_window_done got %b exp 1", window_done); end
    vec_cnt++; if (m_axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL basic_tvalid_t1 got %b exp 1", m_axis_tvalid); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy got %b exp 1", busy); end
    collect(0, nb, nl, us, to);
    vec_cnt++; if (to) begin err_cnt++; $display("FAIL basic_timeout got 1 exp 0"); end
    vec_cnt++; if (nb !== 32) begin err_cnt++; $display("FAIL basic_nbeats got %0d exp 32", nb); end
    vec_cnt++; if (nl !== 1) begin err_cnt++; $display("FAIL basic_nlast got %0d exp 1", nl); end
    for (int k = 0; k < 32; k++) begin
      exp = '0;
      if (k == 0)  exp[15:0]    = 16'd4;
      if (k == 31) exp[511:496] = 16'd2;
      vec_cnt++; if (cap_data[k] !== exp) begin err_cnt++; $display("FAIL basic_beat%0d got %h exp %h", k, cap_data[k], exp); end
      vec_cnt++; if (cap_last[k] !== (k == 31)) begin err_cnt++; $display("FAIL basic_tlast%0d got %b exp %b", k, cap_last[k], (k == 31)); end
    end
    vec_cnt++; if (m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL basic_tvalid_after got %b exp 0", m_axis_tvalid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    vec_cnt++; if (wd_count - wd0 !== 1) begin err_cnt++; $display("FAIL basic_done_pulses got %0d exp 1", wd_count - wd0); end
  endtask

  task automatic test_saturation();
    logic [NN-1:0] sp;
    logic [511:0]  exp;
    int nb, nl, us;
    bit to;
    do_reset();
    cfg_window = 16'd300; cfg_gain = 16'h8000;
    sp = '0; sp[5] = 1'b1;
    for (int s = 0; s < 299; s++) step(sp);
    vec_cnt++; if (window_done !== 1'b0) begin err_cnt++; $display("FAIL sat_early_done got %b exp 0", window_done); end
    step(sp);
    exp = '0; exp[5*16 +: 16] = 16'd32640;
    vec_cnt++; if (window_done !== 1'b1) begin err_cnt++; $display("FAIL sat_window_done got %b exp 1", window_done); end
    vec_cnt++; if (m_axis_tdata !== exp) begin err_cnt++; $display("FAIL sat_gain8000 got %h exp %h", m_axis_tdata, exp); end
    collect(0, nb, nl, us, to);
    vec_cnt++; if (to || nb !== 32) begin err_cnt++; $display("FAIL sat_drain1 got %0d beats exp 32", nb); end
    cfg_gain = 16'hFFFF;
    for (int s = 0; s < 300; s++) step(sp);
    exp = '0; exp[5*16 +: 16] = 16'h7FFF;
    vec_cnt++; if (m_axis_tdata !== exp) begin err_cnt++; $display("FAIL sat_gainffff got %h exp %h", m_axis_tdata, exp); end
    collect(0, nb, nl, us, to);
    vec_cnt++; if (to || nb !== 32) begin err_cnt++; $display("FAIL sat_drain2 got %0d beats exp 32", nb); end
  endtask

  task automatic test_backpressure();
    logic [NN-1:0] sp;
    logic [511:0]  exp;
    int nb, nl, us;
    bit to;
    do_reset();
    cfg_window = 16'd1; cfg_gain = 16'h0100;
    sp = '0;
    for (int k = 0; k < 32; k++) begin
      sp[32*k + k]  = 1'b1;
      sp[32*k + 31] = 1'b1;
    end
    step(sp);
    collect(1, nb, nl, us, to);
    vec_cnt++; if (to) begin err_cnt++; $display("FAIL bp_timeout got 1 exp 0"); end
    vec_cnt++; if (nb !== 32) begin err_cnt++; $display("FAIL bp_nbeats got %0d exp 32", nb); end
    vec_cnt++; if (nl !== 1) begin err_cnt++; $display("FAIL bp_nlast got %0d exp 1", nl); end
    vec_cnt++; if (us !== 0) begin err_cnt++; $display("FAIL bp_stable got %0d changes exp 0", us); end
    for (int k = 0; k < 32; k++) begin
      exp = '0;
      for (int i = 0; i < 32; i++) exp[16*i +: 16] = {15'd0, sp[32*k + i]};
      vec_cnt++; if (cap_data[k] !== exp) begin err_cnt++; $display("FAIL bp_beat%0d got %h exp %h", k, cap_data[k], exp); end
    end
    vec_cnt++; if (cap_last[31] !== 1'b1) begin err_cnt++; $display("FAIL bp_tlast31 got %b exp 1", cap_last[31]); end
  endtask

  task automatic test_overrun();
    logic [NN-1:0] sp1, sp2, sp3;
    logic [511:0]  exp;
    int nb, nl, us;
    bit to;
    do_reset();
    cfg_window = 16'd1; cfg_gain = 16'h0100; m_axis_tready = 1'b0;
    sp1 = '0; sp1[3] = 1'b1; sp1[40] = 1'b1;
    sp2 = '0; sp2[0] = 1'b1;
    sp3 = '0; sp3[1] = 1'b1;
    spikes_valid = 1'b1;
    spikes_in = sp1; tick();
    vec_cnt++; if (window_done !== 1'b1) begin err_cnt++; $display("FAIL ovr_done1 got %b exp 1", window_done); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_flag1 got %b exp 0", overrun); end
    spikes_in = sp2; tick();
    vec_cnt++; if (window_done !== 1'b0) begin err_cnt++; $display("FAIL ovr_done2 got %b exp 0", window_done); end
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_flag2 got %b exp 1", overrun); end
    vec_cnt++; if (dropped_windows !== 16'd1) begin err_cnt++; $display("FAIL ovr_dropped2 got %0d exp 1", dropped_windows); end
    spikes_in = sp3; tick();
    spikes_valid = 1'b0; spikes_in = '0;
    vec_cnt++; if (dropped_windows !== 16'd2) begin err_cnt++; $display("FAIL ovr_dropped3 got %0d exp 2", dropped_windows); end
    collect(0, nb, nl, us, to);
    vec_cnt++; if (to || nb !== 32) begin err_cnt++; $display("FAIL ovr_nbeats got %0d exp 32", nb); end
    for (int k = 0; k < 2; k++) begin
      exp = '0;
      for (int i = 0; i < 32; i++) exp[16*i +: 16] = {15'd0, sp1[32*k + i]};
      vec_cnt++; if (cap_data[k] !== exp) begin err_cnt++; $display("FAIL ovr_beat%0d got %h exp %h", k, cap_data[k], exp); end
    end
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_zero_window();
    logic [NN-1:0] sp;
    logic [511:0]  exp;
    int nb, nl, us, wd0;
    bit to;
    do_reset();
    cfg_window = 16'd0; cfg_gain = 16'h0100;
    wd0 = wd_count;
    sp = '0; sp[2] = 1'b1;
    exp = '0; exp[2*16 +: 16] = 16'd1;
    for (int w = 0; w < 2; w++) begin
      step(sp);
      vec_cnt++; if (window_done !== 1'b1) begin err_cnt++; $display("FAIL zw_done%0d got %b exp 1", w, window_done); end
      vec_cnt++; if (m_axis_tdata !== exp) begin err_cnt++; $display("FAIL zw_beat%0d got %h exp %h", w, m_axis_tdata, exp); end
      collect(0, nb, nl, us, to);
      vec_cnt++; if (to || nb !== 32) begin err_cnt++; $display("FAIL zw_nbeats%0d got %0d exp 32", w, nb); end
    end
    vec_cnt++; if (wd_count - wd0 !== 2) begin err_cnt++; $display("FAIL zw_pulses got %0d exp 2", wd_count - wd0); end
  endtask

  task automatic test_reset_mid_stream();
    logic [NN-1:0] spa, spb, sp7, sp9;
    logic [511:0]  exp;
    int nb, nl, us;
    bit to;
    do_reset();
    cfg_window = 16'd3; cfg_gain = 16'h0100;
    spa = '0; spa[0] = 1'b1;
    spb = spa; spb[33] = 1'b1;
    sp7 = '0; sp7[7] = 1'b1;
    sp9 = '0; sp9[9] = 1'b1;
    step(spa); step(spa); step(spb);
    vec_cnt++; if (m_axis_tvalid !== 1'b1) begin err_cnt++; $display("FAIL rm_tvalid_start got %b exp 1", m_axis_tvalid); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin spikes_in = sp7; spikes_valid = 1'b1; end
      tick();
      spikes_valid = 1'b0; spikes_in = '0;
    end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rm_busy_beat10 got %b exp 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0; m_axis_tready = 1'b0;
    vec_cnt++; if (m_axis_tvalid !== 1'b0) begin err_cnt++; $display("FAIL rm_tvalid got %b exp 0", m_axis_tvalid); end
    vec_cnt++; if (m_axis_tlast !== 1'b0) begin err_cnt++; $display("FAIL rm_tlast got %b exp 0", m_axis_tlast); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rm_busy got %b exp 0", busy); end
    step(sp9); step(sp9);
    vec_cnt++; if (window_done !== 1'b0) begin err_cnt++; $display("FAIL rm_early_done got %b exp 0", window_done); end
    step(sp9);
    exp = '0; exp[9*16 +: 16] = 16'd3;
    vec_cnt++; if (window_done !== 1'b1) begin err_cnt++; $display("FAIL rm_window_done got %b exp 1", window_done); end
    vec_cnt++; if (m_axis_tdata !== exp) begin err_cnt++; $display("FAIL rm_post_beat0 got %h exp %h", m_axis_tdata, exp); end
    collect(0, nb, nl, us, to);
    vec_cnt++; if (to || nb !== 32) begin err_cnt++; $display("FAIL rm_nbeats got %0d exp 32", nb); end
    exp = '0;
    vec_cnt++; if (cap_data[1] !== exp) begin err_cnt++; $display("FAIL rm_post_beat1 got %h exp %h", cap_data[1], exp); end
  endtask

  initial begin
    rst = 1'b1; spikes_in = '0; spikes_valid = 1'b0;
    cfg_window = 16'd1; cfg_gain = 16'h0100; m_axis_tready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_overrun();
    test_zero_window();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
